// File: rtl/game_pkg.sv
// Shared constants for the counting-game input path.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control).
//
// Holds the button-FSM state encoding and the default debounce / long-press
// durations (50 MHz system clock) used by game_input_cond and btn_debounce.
package game_pkg;

    // Button FSM state encoding, shared so the game FSM and debug tooling
    // can decode the debounce state if it is ever exported.
    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    // 20 ms debounce window and 2 s long press at 50 MHz.
    localparam int DEB_CYCLES_DEF  = 1000000;
    localparam int LONG_CYCLES_DEF = 100000000;

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-flop sync, debounce FSM, one-cycle press pulse.
// Latency: press_pulse appears DEB_CYCLES+2 cycles after the raw level settles.
// Backpressure: none; pulses are fire-and-forget.
//
// Ports:
//   clk, rst (sync, active-low) | btn_raw: asynchronous active-high button
//   press_pulse: one cycle per accepted press | long_pulse: once per long hold
// Optional: GAME_INPUT_LONGPRESS_EN builds the long-hold counter when LONG_EN=1;
// otherwise long_pulse is a constant 0.
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter bit LONG_EN     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse,
    output logic long_pulse
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync_meta;
    logic          sync_btn;
    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // Keeps the long-press configuration referenced in every build flavour.
    logic long_cfg_unused;
    assign long_cfg_unused = LONG_EN ^ (LONG_CYCLES > 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_meta   <= 1'b0;
            sync_btn    <= 1'b0;
            state       <= RELEASED;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_meta   <= btn_raw;
            sync_btn    <= sync_meta;
            press_pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (sync_btn) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    // A bounce back to 0 abandons the press attempt.
                    if (!sync_btn) begin
                        state <= RELEASED;
                    end else if (cnt == CNT_MAX) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sync_btn) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // Returning to PRESSED on a bounce means no second pulse.
                    if (sync_btn) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_MAX) begin
                        state <= RELEASED;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

`ifdef GAME_INPUT_LONGPRESS_EN
    if (LONG_EN) begin : g_long
        localparam int LW = $clog2(LONG_CYCLES);
        localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES - 1);

        logic [LW-1:0] long_cnt;
        logic          long_done;

        // Counts only while PRESSED; holds through release bounces and only
        // re-arms once the button is fully released.
        always_ff @(posedge clk) begin
            if (!rst) begin
                long_cnt   <= '0;
                long_done  <= 1'b0;
                long_pulse <= 1'b0;
            end else begin
                long_pulse <= 1'b0;
                if (state == PRESSED) begin
                    if (long_cnt == LONG_MAX) begin
                        if (!long_done) begin
                            long_pulse <= 1'b1;
                            long_done  <= 1'b1;
                        end
                    end else begin
                        long_cnt <= long_cnt + 1'b1;
                    end
                end else if (state == RELEASED || state == PRESS_WAIT) begin
                    long_cnt  <= '0;
                    long_done <= 1'b0;
                end
            end
        end
    end else begin : g_no_long
        assign long_pulse = 1'b0;
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/game_input_cond.sv
// Counting-game input conditioner: clean press pulses and a debounced switch word.
// Latency: DEB_CYCLES+2 cycles from a settled raw level to pulse / sw_stable update.
// Backpressure: none; all outputs are registered one-shot pulses or levels.
//
// Ports:
//   clk, rst (sync, active-low)
//   btn_start_raw, btn_restart_raw, sw_raw[7:0]: asynchronous raw inputs
//   start_pulse, restart_pulse: one cycle per accepted press
//   sw_stable[7:0], sw_changed: debounced switch word and its update strobe
//   power_off_pulse: sw_stable[7] fell 1->0 | long_restart_pulse: long hold
// Optional: GAME_INPUT_LONGPRESS_EN enables long_restart_pulse (else tied 0).
module game_input_cond
    import game_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_raw,
    input  logic       btn_restart_raw,
    input  logic [7:0] sw_raw,
    output logic       start_pulse,
    output logic       restart_pulse,
    output logic [7:0] sw_stable,
    output logic       sw_changed,
    output logic       power_off_pulse,
    output logic       long_restart_pulse
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic start_long_unused;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .LONG_CYCLES(LONG_CYCLES),
        .LONG_EN    (1'b0)
    ) u_start (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_start_raw),
        .press_pulse(start_pulse),
        .long_pulse (start_long_unused)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .LONG_CYCLES(LONG_CYCLES),
        .LONG_EN    (1'b1)
    ) u_restart (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_restart_raw),
        .press_pulse(restart_pulse),
        .long_pulse (long_restart_pulse)
    );

    // The switch bank is debounced as one word: any bit moving restarts the
    // window, so a multi-bit change is only accepted once every bit settles.
    logic [7:0]    sw_meta;
    logic [7:0]    sw_sync;
    logic [7:0]    sw_prev;
    logic [CW-1:0] sw_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_meta         <= '0;
            sw_sync         <= '0;
            sw_prev         <= '0;
            sw_cnt          <= '0;
            sw_stable       <= '0;
            sw_changed      <= 1'b0;
            power_off_pulse <= 1'b0;
        end else begin
            sw_meta         <= sw_raw;
            sw_sync         <= sw_meta;
            sw_prev         <= sw_sync;
            sw_changed      <= 1'b0;
            power_off_pulse <= 1'b0;
            if (sw_sync == sw_stable) begin
                sw_cnt <= '0;
            end else if (sw_sync != sw_prev) begin
                sw_cnt <= '0;
            end else if (sw_cnt == CNT_MAX) begin
                sw_stable       <= sw_sync;
                sw_changed      <= 1'b1;
                power_off_pulse <= sw_stable[7] & ~sw_sync[7];
            end else begin
                sw_cnt <= sw_cnt + 1'b1;
            end
        end
    end

endmodule
